// File: rtl/pcs_deskew_pkg.sv
// Shared parameters, types and alignment-marker constants for the multi-lane PCS receive deskew.
package pcs_deskew_pkg;

  localparam int unsigned LANE_N           = 4;
  localparam int unsigned BLOCK_W          = 66;
  localparam int unsigned MAX_SKEW_BIT_N   = 1856;
  localparam int unsigned MAX_SKEW_BLOCK_N = (MAX_SKEW_BIT_N - BLOCK_W - 1) / BLOCK_W;
  localparam int unsigned DLY_DEPTH        = MAX_SKEW_BLOCK_N + 1;
  localparam int unsigned CNT_W            = $clog2(DLY_DEPTH + 1);

  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2
  } deskew_state_e;

  localparam block_t AM_LANE0 = {2'b10, 64'h00b8896f00477690};
  localparam block_t AM_LANE1 = {2'b10, 64'h00193b0f00e6c4f0};
  localparam block_t AM_LANE2 = {2'b10, 64'h00649a3a009b65c5};
  localparam block_t AM_LANE3 = {2'b10, 64'h00c2865d003d79a2};

  function automatic block_t am_marker(input int lane);
    case (lane)
      0:       return AM_LANE0;
      1:       return AM_LANE1;
      2:       return AM_LANE2;
      3:       return AM_LANE3;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/deskew_lane_dly.sv
// One lane's delay line: output is the input delayed by 1+i_dly cycles.
module deskew_lane_dly
  import pcs_deskew_pkg::*;
(
  input  logic   clk,
  input  logic   nreset,
  input  block_t i_data,
  input  cnt_t   i_dly,
  output block_t o_data_c
);

  block_t r_sr [DLY_DEPTH];

  always_ff @(posedge clk) begin
    if (nreset) begin
      for (int k = 0; k < int'(DLY_DEPTH); k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= i_data;
      for (int k = 1; k < int'(DLY_DEPTH); k++) r_sr[k] <= r_sr[k-1];
    end
  end

  // Tap select; tap 0 is the plain one-cycle register
  always_comb begin
    o_data_c = '0;
    for (int k = 0; k < int'(DLY_DEPTH); k++) begin
      if (i_dly == CNT_W'(k)) o_data_c = r_sr[k];
    end
  end

endmodule

// File: rtl/lane_deskew_rx.sv
// PCS receive lane deskew: measures per-lane marker skew, then delays each lane so markers leave together.
module lane_deskew_rx
  import pcs_deskew_pkg::*;
(
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [LANE_N-1:0]         am_lite_v_i,
  input  logic [LANE_N-1:0]         am_lite_lock_v_i,
  input  logic [LANE_N*BLOCK_W-1:0] data_i,
  output logic                      am_v_o,
  output logic [LANE_N*BLOCK_W-1:0] data_o
);

  localparam cnt_t CNT_LIMIT = CNT_W'(MAX_SKEW_BLOCK_N);

  deskew_state_e     r_state, w_state_nxt;
  logic [LANE_N-1:0] r_marked, w_marked_nxt;
  logic [LANE_N-1:0] w_lost, w_mark_upd, w_dly_zero;
  cnt_t              r_cnt     [LANE_N];
  cnt_t              w_cnt_nxt [LANE_N];
  cnt_t              w_cnt_upd [LANE_N];
  cnt_t              r_dly     [LANE_N];
  cnt_t              w_dly_nxt [LANE_N];
  cnt_t              w_cnt_max;
  logic              r_am_v, w_am_v_nxt, w_restart;

  assign w_lost     = r_marked & ~am_lite_lock_v_i & ~am_lite_v_i;
  assign w_mark_upd = r_marked | am_lite_v_i;

  // Counts as they would be after this cycle; unmarked lanes stay at zero
  always_comb begin
    w_cnt_upd  = '{default: '0};
    w_dly_zero = '0;
    w_cnt_max  = '0;
    for (int l = 0; l < int'(LANE_N); l++) begin
      if (r_marked[l]) w_cnt_upd[l] = r_cnt[l] + CNT_W'(1);
      w_dly_zero[l] = (r_dly[l] == '0);
      if (w_cnt_upd[l] > w_cnt_max) w_cnt_max = w_cnt_upd[l];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_marked_nxt = r_marked;
    w_cnt_nxt    = r_cnt;
    w_dly_nxt    = r_dly;
    w_am_v_nxt   = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      ST_IDLE: w_restart = 1'b1;
      ST_WAIT: begin
        if (|w_lost) begin
          w_restart = 1'b1;
        end else if (&w_mark_upd) begin
          w_marked_nxt = w_mark_upd;
          w_cnt_nxt    = w_cnt_upd;
          w_dly_nxt    = w_cnt_upd;
          w_state_nxt  = ST_LOCKED;
          w_am_v_nxt   = 1'b1;
        end else if (w_cnt_max >= CNT_LIMIT) begin
          w_restart = 1'b1;
        end else begin
          w_marked_nxt = w_mark_upd;
          w_cnt_nxt    = w_cnt_upd;
        end
      end
      ST_LOCKED: begin
        if (|w_lost) w_restart = 1'b1;
        else         w_am_v_nxt = &(am_lite_v_i | ~w_dly_zero);
      end
      default: w_restart = 1'b1;
    endcase
    // Fresh start: markers seen this very cycle are captured without losing a cycle
    if (w_restart) begin
      w_marked_nxt = am_lite_v_i;
      w_cnt_nxt    = '{default: '0};
      w_dly_nxt    = '{default: '0};
      w_am_v_nxt   = 1'b0;
      if (&am_lite_v_i) begin
        w_state_nxt = ST_LOCKED;
        w_am_v_nxt  = 1'b1;
      end else if (|am_lite_v_i) begin
        w_state_nxt = ST_WAIT;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      r_state  <= ST_IDLE;
      r_marked <= '0;
      r_cnt    <= '{default: '0};
      r_dly    <= '{default: '0};
      r_am_v   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_marked <= w_marked_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dly    <= w_dly_nxt;
      r_am_v   <= w_am_v_nxt;
    end
  end

  assign am_v_o = r_am_v;

  for (genvar l = 0; l < int'(LANE_N); l++) begin : g_lane
    deskew_lane_dly u_dly (
      .clk      (clk),
      .nreset   (nreset),
      .i_data   (data_i[l*BLOCK_W +: BLOCK_W]),
      .i_dly    (r_dly[l]),
      .o_data_c (data_o[l*BLOCK_W +: BLOCK_W])
    );
  end

endmodule

// File: tb/tb_lane_deskew_rx.sv
// Scoreboard bench for lane_deskew_rx: directed marker skews, aborts, restart, timeout and reset.
module tb_lane_deskew_rx;
  import pcs_deskew_pkg::*;

  localparam int NL = int'(LANE_N);
  localparam int BW = int'(BLOCK_W);
  localparam int DW = NL * BW;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            nreset;
  logic [NL-1:0]   am_v;
  logic [NL-1:0]   lock;
  logic [DW-1:0]   data_i;
  logic            am_v_o;
  logic [DW-1:0]   data_o;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  lane_deskew_rx dut (
    .clk              (clk),
    .nreset           (nreset),
    .am_lite_v_i      (am_v),
    .am_lite_lock_v_i (lock),
    .data_i           (data_i),
    .am_v_o           (am_v_o),
    .data_o           (data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic block_t filler(input int lane, input int c);
    return {2'b01, 32'(c), 16'(lane), 16'hC3A5};
  endfunction

  function automatic logic [DW-1:0] fill_all(input int c);
    logic [DW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*BW +: BW] = filler(l, c);
    return r;
  endfunction

  function automatic logic [DW-1:0] all_markers();
    logic [DW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*BW +: BW] = am_marker(l);
    return r;
  endfunction

  task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NL-1:0] v, input logic [NL-1:0] lk);
    am_v = v;
    lock = lk;
    for (int l = 0; l < NL; l++) data_i[l*BW +: BW] = v[l] ? am_marker(l) : filler(l, cyc);
    tick();
  endtask

  // Marker on lane l at step sk[l]; aligned markers expected one cycle after the latest
  task automatic send_markers(input int s0, input int s1, input int s2, input int s3,
                              input logic keep_lock);
    int            sk [4];
    int            mx;
    logic [NL-1:0] v;
    logic [NL-1:0] lk;
    exp_t          e;
    sk = '{s0, s1, s2, s3};
    mx = 0;
    for (int l = 0; l < NL; l++) if (sk[l] > mx) mx = sk[l];
    for (int j = 0; j <= mx; j++) begin
      for (int l = 0; l < NL; l++) begin
        v[l]  = (j == sk[l]);
        lk[l] = keep_lock | (j > sk[l]);
      end
      if (j == mx) begin
        e.cyc  = cyc + 1;
        e.data = all_markers();
        exp_q.push_back(e);
      end
      drive(v, lk);
    end
  endtask

  // Monitor: every am_v_o pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (!nreset) begin
      if (am_v_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_am_v_o at cyc %0d: got 1 want 0", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || data_o !== mon_e.data) begin
            errors++;
            $display("FAIL aligned_markers: got cyc %0d data %h want cyc %0d data %h",
                     cyc, data_o, mon_e.cyc, mon_e.data);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL aligned_markers missed at cyc %0d: got am_v_o 0 want 1", cyc);
        exp_q.delete(0);
      end
    end
  end

  initial begin
    int c0;
    nreset = 1'b1;
    am_v   = '0;
    lock   = '0;
    data_i = '1;
    repeat (3) tick();
    check_vec("reset_am_v_o", DW'(am_v_o), '0);
    check_vec("reset_data_o", data_o, '0);
    nreset = 1'b0;

    // All lanes mark together; then delay must be a plain register
    drive('0, '0);
    send_markers(0, 0, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      c0 = cyc;
      drive('0, '1);
      check_vec("zero_dly_passthru", data_o, fill_all(c0));
    end

    // Abort to IDLE, then skews {0,3,1,4}, then a re-send while LOCKED
    drive('0, '0);
    send_markers(0, 3, 1, 4, 1'b0);
    repeat (3) drive('0, '1);
    send_markers(0, 3, 1, 4, 1'b1);
    repeat (2) drive('0, '1);

    // Lane 2 loses lock for one cycle, realign with skews {2,0,4,1}
    drive('0, 4'b1011);
    send_markers(2, 0, 4, 1, 1'b0);
    repeat (2) drive('0, '1);

    // Abort and restart in the same cycle: lane 1 marker while all locks drop
    send_markers(1, 0, 2, 3, 1'b0);
    repeat (2) drive('0, '1);

    // Partial marking, marked lane 0 lost, lane 3 alone must not align
    drive('0, '0);
    drive(4'b0111, 4'b0000);
    drive(4'b0000, 4'b0110);
    drive(4'b1000, 4'b0110);
    check_vec("partial_no_align", DW'(am_v_o), '0);
    for (int k = 0; k < 3; k++) begin
      drive('0, 4'b1110);
      check_vec("partial_wait", DW'(am_v_o), '0);
    end

    // Maximum tolerated skew of 27 blocks
    drive('0, '0);
    send_markers(0, 27, 27, 27, 1'b0);
    repeat (2) drive('0, '1);

    // Timeout: lane 0 alone for 27 cycles, late markers must not align
    drive('0, '0);
    drive(4'b0001, 4'b0000);
    repeat (27) drive('0, 4'b0001);
    drive(4'b1110, 4'b0001);
    check_vec("timeout_no_align", DW'(am_v_o), '0);
    for (int k = 0; k < 3; k++) begin
      drive('0, '1);
      check_vec("timeout_idle", DW'(am_v_o), '0);
    end

    // Mid-run reset
    nreset = 1'b1;
    drive('0, '1);
    check_vec("midrun_reset_data_o", data_o, '0);
    check_vec("midrun_reset_am_v_o", DW'(am_v_o), '0);
    nreset = 1'b0;
    repeat (3) drive('0, '0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
